// File: rtl/riscv_defs_pkg.sv
// rtl/riscv_defs_pkg.sv - RISC-V opcode constants, format type codes and default XLEN
package riscv_defs;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [2:0] {
    TYPE_R   = 3'd0,
    TYPE_I   = 3'd1,
    TYPE_S   = 3'd2,
    TYPE_L   = 3'd3,
    TYPE_B   = 3'd4,
    TYPE_J   = 3'd5,
    TYPE_U   = 3'd6,
    TYPE_INV = 3'd7
  } instr_type_e;

endpackage

// File: rtl/decode_fields.sv
// rtl/decode_fields.sv - combinational RV32I/RV64I field split, format class and immediate
module decode_fields
  import riscv_defs::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [31:0]     instr_i,
  output logic [6:0]      opcode_o,
  output logic [2:0]      funct3_o,
  output logic [6:0]      funct7_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic            rs1_en_o,
  output logic            rs2_en_o,
  output logic            rd_en_o,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      type_o,
  output logic            illegal_o
);

  instr_type_e typ;
  logic        rd_use;
  logic [31:0] imm32;

  always_comb begin
    typ       = TYPE_INV;
    illegal_o = 1'b0;
    rs1_en_o  = 1'b0;
    rs2_en_o  = 1'b0;
    rd_use    = 1'b0;
    imm32     = '0;
    case (instr_i[6:0])
      OP_R: begin
        typ = TYPE_R; rs1_en_o = 1'b1; rs2_en_o = 1'b1; rd_use = 1'b1;
      end
      OP_I, OP_L: begin
        typ = (instr_i[6:0] == OP_I) ? TYPE_I : TYPE_L;
        rs1_en_o = 1'b1; rd_use = 1'b1;
        imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      end
      OP_S: begin
        typ = TYPE_S; rs1_en_o = 1'b1; rs2_en_o = 1'b1;
        imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      end
      OP_B: begin
        typ = TYPE_B; rs1_en_o = 1'b1; rs2_en_o = 1'b1;
        imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      end
      OP_JAL: begin
        typ = TYPE_J; rd_use = 1'b1;
        imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      end
      OP_JALR: begin
        typ = TYPE_J; rs1_en_o = 1'b1; rd_use = 1'b1;
        imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      end
      OP_LUI, OP_AUIPC: begin
        typ = TYPE_U; rd_use = 1'b1;
        imm32 = {instr_i[31:12], 12'b0};
      end
      default: illegal_o = 1'b1;
    endcase
  end

  // Writes to x0 are architecturally discarded, so no writeback is requested.
  assign rd_en_o  = rd_use && (instr_i[11:7] != 5'd0);
  assign opcode_o = instr_i[6:0];
  assign funct3_o = instr_i[14:12];
  assign funct7_o = instr_i[31:25];
  assign rs1_o    = rs1_en_o ? instr_i[19:15] : 5'd0;
  assign rs2_o    = rs2_en_o ? instr_i[24:20] : 5'd0;
  assign rd_o     = rd_en_o ? instr_i[11:7] : 5'd0;
  assign imm_o    = XLEN'($signed(imm32));
  assign type_o   = typ;

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered decode stage with handshake, flush and counters; DECODE_SKID_EN adds a skid entry
module decode_stage
  import riscv_defs::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [6:0]       out_opcode,
  output logic [2:0]       out_funct3,
  output logic [6:0]       out_funct7,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic             out_rs1_en,
  output logic             out_rs2_en,
  output logic             out_rd_en,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_type,
  output logic             out_illegal,
  output logic [CNT_W-1:0] cnt_accepted,
  output logic [CNT_W-1:0] cnt_illegal
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            rs1_en;
    logic            rs2_en;
    logic            rd_en;
    logic [XLEN-1:0] imm;
    logic [2:0]      typ;
    logic            illegal;
  } entry_t;

  logic [6:0]      f_opcode, f_funct7;
  logic [2:0]      f_funct3, f_type;
  logic [4:0]      f_rs1, f_rs2, f_rd;
  logic            f_rs1_en, f_rs2_en, f_rd_en, f_illegal;
  logic [XLEN-1:0] f_imm;

  decode_fields #(.XLEN(XLEN)) u_fields (
    .instr_i   (in_instr),
    .opcode_o  (f_opcode),
    .funct3_o  (f_funct3),
    .funct7_o  (f_funct7),
    .rs1_o     (f_rs1),
    .rs2_o     (f_rs2),
    .rd_o      (f_rd),
    .rs1_en_o  (f_rs1_en),
    .rs2_en_o  (f_rs2_en),
    .rd_en_o   (f_rd_en),
    .imm_o     (f_imm),
    .type_o    (f_type),
    .illegal_o (f_illegal)
  );

  entry_t dec, out_q, out_d;
  logic   out_valid_q, out_valid_d, in_fire;
  logic [CNT_W-1:0] cnt_acc_q, cnt_acc_d, cnt_ill_q, cnt_ill_d;

  always_comb begin
    dec = '{pc: in_pc, opcode: f_opcode, funct3: f_funct3, funct7: f_funct7,
            rs1: f_rs1, rs2: f_rs2, rd: f_rd, rs1_en: f_rs1_en, rs2_en: f_rs2_en,
            rd_en: f_rd_en, imm: f_imm, typ: f_type, illegal: f_illegal};
  end

  // A flushed cycle never accepts, so nothing dropped by flush reaches the counters.
  assign in_fire = in_valid && in_ready && !flush;

`ifdef DECODE_SKID_EN
  entry_t skid_q, skid_d;
  logic   skid_valid_q, skid_valid_d, in_ready_q;

  assign in_ready = in_ready_q;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= !skid_valid_d;
    end
  end
`else
  assign in_ready = !out_valid_q || out_ready;

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (in_fire) begin
      out_d       = dec;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end
`endif

  always_comb begin
    cnt_acc_d = cnt_acc_q;
    cnt_ill_d = cnt_ill_q;
    if (in_fire && cnt_acc_q != '1) cnt_acc_d = cnt_acc_q + CNT_W'(1);
    if (in_fire && dec.illegal && cnt_ill_q != '1) cnt_ill_d = cnt_ill_q + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_q       <= '0;
      out_q.typ   <= TYPE_INV;
      out_valid_q <= 1'b0;
      cnt_acc_q   <= '0;
      cnt_ill_q   <= '0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      cnt_acc_q   <= cnt_acc_d;
      cnt_ill_q   <= cnt_ill_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_pc       = out_q.pc;
  assign out_opcode   = out_q.opcode;
  assign out_funct3   = out_q.funct3;
  assign out_funct7   = out_q.funct7;
  assign out_rs1      = out_q.rs1;
  assign out_rs2      = out_q.rs2;
  assign out_rd       = out_q.rd;
  assign out_rs1_en   = out_q.rs1_en;
  assign out_rs2_en   = out_q.rs2_en;
  assign out_rd_en    = out_q.rd_en;
  assign out_imm      = out_q.imm;
  assign out_type     = out_q.typ;
  assign out_illegal  = out_q.illegal;
  assign cnt_accepted = cnt_acc_q;
  assign cnt_illegal  = cnt_ill_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage at XLEN 32 and 64 (honours DECODE_SKID_EN)
module tb_decode_stage;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc32;
  logic [63:0] in_pc64;

  logic        in_ready_a, out_valid_a, rs1en_a, rs2en_a, rden_a, ill_a;
  logic [31:0] out_pc_a, out_imm_a;
  logic [6:0]  opc_a, f7_a;
  logic [2:0]  f3_a, type_a;
  logic [4:0]  rs1_a, rs2_a, rd_a;
  logic [15:0] cacc_a, cill_a;

  logic        in_ready_b, out_valid_b, rs1en_b, rs2en_b, rden_b, ill_b;
  logic [63:0] out_pc_b, out_imm_b;
  logic [6:0]  opc_b, f7_b;
  logic [2:0]  f3_b, type_b;
  logic [4:0]  rs1_b, rs2_b, rd_b;
  logic [15:0] cacc_b, cill_b;

  decode_stage #(.XLEN(32), .CNT_W(16)) u_dut32 (
    .clock(clock), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_instr(in_instr), .in_pc(in_pc32), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_pc(out_pc_a), .out_opcode(opc_a), .out_funct3(f3_a), .out_funct7(f7_a),
    .out_rs1(rs1_a), .out_rs2(rs2_a), .out_rd(rd_a), .out_rs1_en(rs1en_a), .out_rs2_en(rs2en_a),
    .out_rd_en(rden_a), .out_imm(out_imm_a), .out_type(type_a), .out_illegal(ill_a),
    .cnt_accepted(cacc_a), .cnt_illegal(cill_a)
  );

  decode_stage #(.XLEN(64), .CNT_W(16)) u_dut64 (
    .clock(clock), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_instr(in_instr), .in_pc(in_pc64), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_pc(out_pc_b), .out_opcode(opc_b), .out_funct3(f3_b), .out_funct7(f7_b),
    .out_rs1(rs1_b), .out_rs2(rs2_b), .out_rd(rd_b), .out_rs1_en(rs1en_b), .out_rs2_en(rs2en_b),
    .out_rd_en(rden_b), .out_imm(out_imm_b), .out_type(type_b), .out_illegal(ill_b),
    .cnt_accepted(cacc_b), .cnt_illegal(cill_b)
  );

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  typ;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  en;   // {rs1_en, rs2_en, rd_en}
    logic [63:0] imm;
    logic        ill;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] pc;
  } exp_t;

  vec_t vec[12];
  exp_t sbq[$];
  int   n_vec = 0, n_bad = 0, n_pop = 0;
  int   exp_acc = 0, exp_ill = 0;
  logic [31:0] pc_next = 32'h0000_1000;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic send(input int idx);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_instr = vec[idx].instr;
    in_pc32  = pc_next;
    in_pc64  = {32'h0000_00A5, pc_next};
    forever begin
      @(negedge clock);
      if (in_ready_a && !flush && reset_n) begin
        sbq.push_back('{idx: idx, pc: pc_next});
        exp_acc++;
        if (vec[idx].ill) exp_ill++;
        pc_next += 32'd4;
        break;
      end
      t++;
      if (t > 50) begin
        chk("send_timeout", {63'd0, in_ready_a}, 64'd1);
        break;
      end
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  exp_t e;
  vec_t v;
  always @(negedge clock) begin
    if (reset_n && !flush && out_valid_a) begin
      if (sbq.size() == 0) begin
        chk("spurious_out", {63'd0, out_valid_a}, 64'd0);
      end else if (out_ready) begin
        e = sbq.pop_front();
        v = vec[e.idx];
        n_pop++;
        chk("type", type_a, v.typ);
        chk("illegal", ill_a, v.ill);
        chk("rs1", rs1_a, v.rs1);
        chk("rs2", rs2_a, v.rs2);
        chk("rd", rd_a, v.rd);
        chk("enables", {rs1en_a, rs2en_a, rden_a}, v.en);
        chk("imm32", out_imm_a, {32'd0, v.imm[31:0]});
        chk("imm64", out_imm_b, v.imm);
        chk("pc32", out_pc_a, e.pc);
        chk("pc64", out_pc_b, {32'h0000_00A5, e.pc});
        chk("raw_fields", {opc_a, f3_a, f7_a}, {v.instr[6:0], v.instr[14:12], v.instr[31:25]});
        chk("type64", type_b, v.typ);
        chk("valid64", out_valid_b, 64'd1);
      end else begin
        chk("stall_pc", out_pc_a, sbq[0].pc);
      end
    end
  end

  task automatic check_reset_state(input string tag);
    chk({tag, "_valid"}, out_valid_a, 0);
    chk({tag, "_type"}, type_a, 7);
    chk({tag, "_illegal"}, ill_a, 0);
    chk({tag, "_imm"}, out_imm_b, 0);
    chk({tag, "_pc"}, out_pc_a, 0);
    chk({tag, "_regs"}, {rs1_a, rs2_a, rd_a, rs1en_a, rs2en_a, rden_a}, 0);
    chk({tag, "_cnt"}, {cacc_a, cill_a, cacc_b}, 0);
    chk({tag, "_type64"}, type_b, 7);
  endtask

  int t0, acc_before, pop_before;

  initial begin
    vec[0]  = '{32'hFFF00093, 3'd1, 5'd0, 5'd0, 5'd1,  3'b101, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vec[1]  = '{32'hFE208EE3, 3'd4, 5'd1, 5'd2, 5'd0,  3'b110, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
    vec[2]  = '{32'h123452B7, 3'd6, 5'd0, 5'd0, 5'd5,  3'b001, 64'h0000_0000_1234_5000, 1'b0};
    vec[3]  = '{32'h0020A423, 3'd2, 5'd1, 5'd2, 5'd0,  3'b110, 64'h0000_0000_0000_0008, 1'b0};
    vec[4]  = '{32'h00000000, 3'd7, 5'd0, 5'd0, 5'd0,  3'b000, 64'h0,                   1'b1};
    vec[5]  = '{32'h002081B3, 3'd0, 5'd1, 5'd2, 5'd3,  3'b111, 64'h0,                   1'b0};
    vec[6]  = '{32'hFF812003, 3'd3, 5'd2, 5'd0, 5'd0,  3'b100, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0};
    vec[7]  = '{32'h001000EF, 3'd5, 5'd0, 5'd0, 5'd1,  3'b001, 64'h0000_0000_0000_0800, 1'b0};
    vec[8]  = '{32'h00008067, 3'd5, 5'd1, 5'd0, 5'd0,  3'b100, 64'h0,                   1'b0};
    vec[9]  = '{32'h80000517, 3'd6, 5'd0, 5'd0, 5'd10, 3'b001, 64'hFFFF_FFFF_8000_0000, 1'b0};
    vec[10] = '{32'hFFFFFFFF, 3'd7, 5'd0, 5'd0, 5'd0,  3'b000, 64'h0,                   1'b1};
    vec[11] = '{32'h7FF00093, 3'd1, 5'd0, 5'd0, 5'd1,  3'b101, 64'h0000_0000_0000_07FF, 1'b0};

    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_pc32 = '0; in_pc64 = '0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    check_reset_state("reset");
    chk("reset_in_ready", in_ready_a, 1);
    @(posedge clock); #1;

    // Table pass at full rate: first vector also checks single-cycle latency.
    send(0);
    chk("latency", out_valid_a, 1);
    t0 = $time;
    for (int i = 1; i < 12; i++) send(i);
    chk("throughput", ($time - t0) / 10, 11);
    repeat (2) @(posedge clock); #1;
    chk("drain_table", sbq.size(), 0);
    chk("cnt_accepted", cacc_a, exp_acc);
    chk("cnt_illegal", cill_a, exp_ill);
    chk("cnt_illegal64", cill_b, exp_ill);

    // Stream of four with the consumer stalled for three cycles.
    out_ready = 1'b0;
    acc_before = exp_acc;
    pop_before = n_pop;
    fork
      begin
        for (int k = 0; k < 4; k++) send(k + 1);
      end
      begin
        repeat (3) @(posedge clock);
        #1;
`ifdef DECODE_SKID_EN
        chk("stall_accepts", exp_acc - acc_before, 2);
`else
        chk("stall_accepts", exp_acc - acc_before, 1);
`endif
        chk("stall_in_ready", in_ready_a, 0);
        out_ready = 1'b1;
      end
    join
    repeat (3) @(posedge clock); #1;
    chk("stream_count", n_pop - pop_before, 4);
    chk("drain_stream", sbq.size(), 0);

    // Flush together with a held entry and an offered instruction.
    out_ready = 1'b0;
    send(5);
    acc_before = exp_acc;
    in_valid = 1'b1; in_instr = vec[2].instr; flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0; in_valid = 1'b0;
    sbq.delete();
    chk("flush_valid", out_valid_a, 0);
    chk("flush_cnt", cacc_a, acc_before);
    chk("flush_in_ready", in_ready_a, 1);
    out_ready = 1'b1;
    @(posedge clock); #1;
    chk("flush_no_leak", out_valid_a, 0);

    // Reset while an instruction is held and another is offered.
    out_ready = 1'b0;
    send(1);
    in_valid = 1'b1; in_instr = vec[3].instr; out_ready = 1'b1; reset_n = 1'b0;
    @(posedge clock); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    sbq.delete();
    exp_acc = 0; exp_ill = 0;
    check_reset_state("midreset");
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk("post_reset_in_ready", in_ready_a, 1);

    // A lone illegal instruction after reset bumps both counters to 1.
    out_ready = 1'b1;
    send(4);
    repeat (2) @(posedge clock); #1;
    chk("illegal_cnt_acc", cacc_a, 1);
    chk("illegal_cnt_ill", cill_a, 1);
    chk("drain_final", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
